shiftreg_xfer: RTL and testbench

- Parametrised N-bit full-duplex shift engine. Parallel-loads a word, shifts a programmable number of bits out on sout while capturing sin, then flags completion.
- Replaces the fixed 8-bit shift register wherever a serial link (SPI-like, UART data path, debug scan) needs direction control, a bit count and a busy/done handshake.

---
 rtl/shiftreg_xfer.sv | 112 +++++++++++
 tb/tb_shiftreg_xfer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_xfer.sv
// Parametrised N-bit full-duplex shift engine with direction, bit count and busy/done handshake.
// Optional build macro SHIFTREG_XFER_ROTATE_EN adds a 'rot' input that recirculates the outgoing bit instead of sin.
module shiftreg_xfer #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
`ifdef SHIFTREG_XFER_ROTATE_EN
  input  logic          rot,
`endif
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          dir,
  input  logic [CW-1:0] len,
  input  logic          en,
  input  logic [N-1:0]  d,
  input  logic          sin,
  output logic [N-1:0]  q,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic [CW-1:0] lenClamped;
  logic          inBit;

  // Requests longer than the register are clamped rather than wrapped.
  assign lenClamped = (len > CW'(N)) ? CW'(N) : len;

`ifdef SHIFTREG_XFER_ROTATE_EN
  logic rot_q, rot_d;

  assign inBit = rot_q ? (dir_q ? shift_q[0] : shift_q[N-1]) : sin;
`else
  assign inBit = sin;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
`ifdef SHIFTREG_XFER_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = d;
          dir_d   = dir;
          cnt_d   = lenClamped;
`ifdef SHIFTREG_XFER_ROTATE_EN
          rot_d   = rot;
`endif
          if (lenClamped != '0) begin
            state_d = SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (en) begin
          shift_d = dir_q ? {inBit, shift_q[N-1:1]} : {shift_q[N-2:0], inBit};
          cnt_d   = cnt_q - CW'(1);
          // The completing shift and the done pulse share the same edge.
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFTREG_XFER_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
`ifdef SHIFTREG_XFER_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign q    = shift_q;
  assign sout = dir_q ? shift_q[0] : shift_q[N-1];
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_shiftreg_xfer.sv
// Scoreboard bench for shiftreg_xfer: directed transfers push expected sout bits and
// completion records; a negedge monitor pops and compares them as the DUT produces them.
module tb_shiftreg_xfer;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic [N-1:0] qVal;
    int           busyCycles;
  } expRec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          dir;
  logic [CW-1:0] len;
  logic          en;
  logic [N-1:0]  d;
  logic          sin;
  logic          rot;
  logic [N-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  int testsRun = 0;
  int testsFailed = 0;
  int busyRun = 0;

  expRec_t expQ[$];
  logic    soutQ[$];

  shiftreg_xfer #(.N(N), .CW(CW)) dut (
`ifdef SHIFTREG_XFER_ROTATE_EN
    .rot   (rot),
`endif
    .clk   (clk),
    .reset (reset),
    .start (start),
    .dir   (dir),
    .len   (len),
    .en    (en),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: done pops a completion record, every enabled busy cycle pops one sout bit.
  always @(negedge clk) begin
    if (!reset) begin
      busyRun = 0;
    end else begin
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", 32'd1, 32'd0);
        end else begin
          expRec_t rec;
          rec = expQ.pop_front();
          checkOutput("q at done", 32'(q), 32'(rec.qVal));
          checkOutput("busy cycles", 32'(busyRun), 32'(rec.busyCycles));
        end
        busyRun = 0;
      end
      if (busy) begin
        busyRun++;
        if (en) begin
          if (soutQ.size() == 0) begin
            checkOutput("unexpected shift", 32'd1, 32'd0);
          end else begin
            logic expBit;
            expBit = soutQ.pop_front();
            checkOutput("sout bit", 32'(sout), 32'(expBit));
          end
        end
      end
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Issues one transfer starting now (just after an edge) and returns in the done cycle.
  task automatic applyStimulus(input logic [N-1:0] dIn, input logic dirIn, input logic [CW-1:0] lenIn,
                               input logic [N-1:0] sinWord, input logic stall, input logic holdStart,
                               input int expShifts, input logic [N-1:0] expSout, input logic [N-1:0] expQVal,
                               input int expBusy);
    expRec_t rec;
    int shifts;
    int cyc;
    for (int i = 0; i < expShifts; i++) soutQ.push_back(expSout[N-1-i]);
    rec.qVal = expQVal;
    rec.busyCycles = expBusy;
    expQ.push_back(rec);
    d     = dIn;
    dir   = dirIn;
    len   = lenIn;
    start = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    start = holdStart;
    checkOutput("q after load", 32'(q), 32'(dIn));
    checkOutput("busy after start", 32'(busy), (expShifts > 0) ? 32'd1 : 32'd0);
    if (holdStart) begin
      d   = ~dIn;
      dir = ~dirIn;
      len = CW'(1);
    end
    shifts = 0;
    cyc = 0;
    while (shifts < expShifts && cyc < 64) begin
      en  = stall ? (cyc % 2 == 0) : 1'b1;
      sin = dirIn ? sinWord[shifts] : sinWord[N-1-shifts];
      @(posedge clk);
      #1;
      if (en) shifts++;
      cyc++;
    end
    en    = 1'b0;
    start = 1'b0;
    checkOutput("done pulse", 32'(done), 32'd1);
    checkOutput("busy low at done", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    dir   = 1'b0;
    len   = '0;
    en    = 1'b0;
    d     = '0;
    sin   = 1'b0;
    rot   = 1'b0;
    #12;
    checkOutput("reset q", 32'(q), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sout", 32'(sout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);

    // Abort mid-transfer: three shifts of A5 then asynchronous reset.
    soutQ.push_back(1'b1);
    soutQ.push_back(1'b0);
    soutQ.push_back(1'b1);
    d = 8'hA5; dir = 1'b0; len = CW'(8); sin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort q", 32'(q), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort sout", 32'(sout), 32'd0);
    en = 1'b0;
    idle(2);
    checkOutput("abort done", 32'(done), 32'd0);
    reset = 1'b1;
    idle(1);

    // MSB-first full word, sin carries 3C.
    applyStimulus(8'hA5, 1'b0, CW'(8), 8'h3C, 1'b0, 1'b0, 8, 8'b1010_0101, 8'h3C, 8);
    idle(2);
    // LSB-first, four bits with en stalls, sin held high.
    applyStimulus(8'h81, 1'b1, CW'(4), 8'hFF, 1'b1, 1'b0, 4, 8'b1000_0000, 8'hF8, 7);
    idle(2);
    // Zero length completes immediately.
    applyStimulus(8'h5C, 1'b0, CW'(0), 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h5C, 0);
    idle(2);
    // Length 12 is clamped to 8 shifts.
    applyStimulus(8'h5A, 1'b0, CW'(12), 8'h00, 1'b0, 1'b0, 8, 8'b0101_1010, 8'h00, 8);
    idle(1);
    checkOutput("clamp busy after", 32'(busy), 32'd0);
    checkOutput("clamp done after", 32'(done), 32'd0);
    idle(1);
    // start held high with new d/dir/len while busy must be ignored.
    applyStimulus(8'hF1, 1'b1, CW'(3), 8'h00, 1'b0, 1'b1, 3, 8'b1000_0000, 8'h1E, 3);
    idle(2);
    // Back-to-back: second start issued in the done cycle of the first.
    applyStimulus(8'hC0, 1'b0, CW'(2), 8'hC0, 1'b0, 1'b0, 2, 8'b1100_0000, 8'h03, 2);
    applyStimulus(8'h0F, 1'b0, CW'(8), 8'hA5, 1'b0, 1'b0, 8, 8'b0000_1111, 8'hA5, 8);
    idle(2);
`ifdef SHIFTREG_XFER_ROTATE_EN
    rot = 1'b1;
    applyStimulus(8'hC3, 1'b0, CW'(8), 8'h00, 1'b0, 1'b0, 8, 8'b1100_0011, 8'hC3, 8);
    idle(2);
    applyStimulus(8'hC3, 1'b0, CW'(1), 8'h00, 1'b0, 1'b0, 1, 8'b1000_0000, 8'h87, 1);
    idle(2);
    rot = 1'b0;
`endif
    idle(3);
    checkOutput("pending completions", 32'(expQ.size()), 32'd0);
    checkOutput("pending sout bits", 32'(soutQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
